// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the registered ALU (alu_pipe) and its multiplier.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd2;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd3;
  localparam logic [OP_W-1:0] OP_AND  = 4'd4;
  localparam logic [OP_W-1:0] OP_NAND = 4'd5;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd6;
  localparam logic [OP_W-1:0] OP_OR   = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_if.sv
// Operation/result handshake bundle between the register-file read stage, alu_pipe and writeback.
interface alu_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero, illegal
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per cycle for WIDTH cycles.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CNT_W'(WIDTH);
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  // The final partial sum is handed out combinationally so the caller can
  // register it on the last iteration edge.
  assign done = busy_q && (cnt_q == CNT_W'(1));
  assign prod = acc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    acc_q    <= acc_d;
    mplier_q <= mplier_d;
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and a one-entry result register.
// Define ALU_MUL_EN to add the iterative multiplier (op 8); otherwise op 8 is illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic             accept;
  logic             idle;
  logic             in_ready;
  logic             is_mul;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ovf_add, ovf_sub;
  logic [WIDTH-1:0] res_c;
  logic             carry_c, ovf_c, ill_c;

  logic             ld;
  logic [WIDTH-1:0] ld_res;
  logic             ld_carry, ld_ovf, ld_ill;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  function automatic logic sgn_ovf(input logic xs, input logic ys, input logic rs);
    return (xs == ys) && (rs != xs);
  endfunction

`ifdef ALU_MUL_EN
  logic [0:0]         state_q, state_d;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign idle      = (state_q == ST_IDLE);
  assign mul_start = accept && is_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`else
  assign idle = 1'b1;
`endif

  assign in_ready = idle && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign sum     = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff    = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH + 1)'(1);
  assign ovf_add = sgn_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], sum[WIDTH-1]);
  assign ovf_sub = sgn_ovf(bus.a[WIDTH-1], ~bus.b[WIDTH-1], diff[WIDTH-1]);

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    ill_c   = 1'b0;
    is_mul  = 1'b0;
    case (bus.op)
      OP_ADD:  begin res_c = sum[WIDTH-1:0];  carry_c = sum[WIDTH];  ovf_c = ovf_add; end
      OP_SUB:  begin res_c = diff[WIDTH-1:0]; carry_c = diff[WIDTH]; ovf_c = ovf_sub; end
      OP_SLT:  begin
        // Signed less-than is N xor V of a-b, which stays correct across overflow.
        res_c = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
        ovf_c = ovf_sub;
      end
      OP_XOR:  res_c = bus.a ^ bus.b;
      OP_AND:  res_c = bus.a & bus.b;
      OP_NAND: res_c = ~(bus.a & bus.b);
      OP_NOR:  res_c = ~(bus.a | bus.b);
      OP_OR:   res_c = bus.a | bus.b;
`ifdef ALU_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`endif
      default: ill_c = 1'b1;
    endcase
  end

  // Result register load select: single-cycle op at accept, or multiplier completion.
  always_comb begin
    ld       = accept && !is_mul;
    ld_res   = res_c;
    ld_carry = carry_c;
    ld_ovf   = ovf_c;
    ld_ill   = ill_c;
`ifdef ALU_MUL_EN
    state_d = state_q;
    if (accept && is_mul) state_d = ST_MUL;
    if ((state_q == ST_MUL) && mul_done) begin
      ld       = 1'b1;
      ld_res   = mul_prod[WIDTH-1:0];
      ld_carry = |mul_prod[2*WIDTH-1:WIDTH];
      ld_ovf   = 1'b0;
      ld_ill   = 1'b0;
      state_d  = ST_IDLE;
    end
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    if (bus.out_ready) out_valid_d = 1'b0;
    if (ld) begin
      out_valid_d = 1'b1;
      result_d    = ld_res;
      carry_d     = ld_carry;
      overflow_d  = ld_ovf;
      zero_d      = (ld_res == '0);
      illegal_d   = ld_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= ST_IDLE;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
`ifdef ALU_MUL_EN
      state_q     <= state_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule
